// File: rtl/start_fade_ctrl.sv
// Start-screen fade controller: frame-locked brightness ramp applied to the
// palette colour (black -> fade-in -> show -> fade-out on start -> done).
module start_fade_ctrl #(
   parameter int unsigned FRAMES_PER_STEP = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       vsync,
   input  logic       start_key,
   input  logic       blank,
   input  logic [3:0] pix_index,
   output logic [3:0] pal_index,
   input  logic [3:0] pal_red,
   input  logic [3:0] pal_green,
   input  logic [3:0] pal_blue,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       busy,
   output logic       fade_done
);

   localparam int unsigned CW = 4;
   localparam int unsigned LW = 5;
   localparam int unsigned FW = 4;
   localparam int unsigned PW = 9;

   localparam logic [LW-1:0] LVL_LAST_UP = LW'(15);
   localparam logic [LW-1:0] LVL_LAST_DN = LW'(1);
   localparam logic [FW-1:0] FCNT_LAST   = FW'(FRAMES_PER_STEP - 1);

   typedef enum logic [2:0] {
      ST_BLACK,
      ST_FADE_IN,
      ST_SHOW,
      ST_FADE_OUT,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rgb_t;

   state_e        state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          pending_q, pending_d;
   logic          vsync_q, vsync_d;
   logic          start_q, start_d;
   logic          busy_q, busy_d;
   logic          fade_done_q, fade_done_d;
   rgb_t          rgb_q, rgb_d;

   logic          tick;
   logic          start_edge;
   logic          step;

   // Brightness scaling: upper nibble of colour x level (level 16 is identity).
   function automatic logic [CW-1:0] scale(input logic [CW-1:0] c,
                                           input logic [LW-1:0] lvl);
      logic [PW-1:0] prod;
      prod = PW'(c) * PW'(lvl);
      return prod[7:4];
   endfunction

   assign pal_index = pix_index;

   always_comb begin
      vsync_d     = vsync;
      start_d     = start_key;
      state_d     = state_q;
      level_d     = level_q;
      fcnt_d      = fcnt_q;
      pending_d   = pending_q;
      fade_done_d = 1'b0;

      tick       = vsync_q & ~vsync;
      start_edge = ~start_q & start_key;
      step       = tick && (fcnt_q == FCNT_LAST);

      // Step counter advances only on frame ticks while fading.
      if ((state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT)) begin
         if (step) begin
            fcnt_d = '0;
         end else if (tick) begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end

      case (state_q)
         ST_BLACK: begin
            if (start_edge) pending_d = 1'b1;
            if (tick) begin
               state_d = ST_FADE_IN;
               fcnt_d  = '0;
            end
         end
         ST_FADE_IN: begin
            if (start_edge) pending_d = 1'b1;
            if (step) begin
               level_d = level_q + LW'(1);
               if (level_q == LVL_LAST_UP) begin
                  fcnt_d = '0;
                  // A press that arrived during the ramp skips the hold.
                  if (pending_q || start_edge) begin
                     state_d   = ST_FADE_OUT;
                     pending_d = 1'b0;
                  end else begin
                     state_d = ST_SHOW;
                  end
               end
            end
         end
         ST_SHOW: begin
            if (start_edge) begin
               state_d   = ST_FADE_OUT;
               fcnt_d    = '0;
               pending_d = 1'b0;
            end
         end
         ST_FADE_OUT: begin
            if (step) begin
               level_d = level_q - LW'(1);
               if (level_q == LVL_LAST_DN) begin
                  state_d     = ST_DONE;
                  fcnt_d      = '0;
                  fade_done_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
         end
         default: begin
            state_d   = ST_BLACK;
            level_d   = '0;
            fcnt_d    = '0;
            pending_d = 1'b0;
         end
      endcase

      busy_d = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);

      if (blank) begin
         rgb_d.r = scale(pal_red, level_q);
         rgb_d.g = scale(pal_green, level_q);
         rgb_d.b = scale(pal_blue, level_q);
      end else begin
         rgb_d = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_BLACK;
         level_q     <= '0;
         fcnt_q      <= '0;
         pending_q   <= 1'b0;
         vsync_q     <= 1'b0;
         start_q     <= 1'b1;
         busy_q      <= 1'b0;
         fade_done_q <= 1'b0;
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         fcnt_q      <= fcnt_d;
         pending_q   <= pending_d;
         vsync_q     <= vsync_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         fade_done_q <= fade_done_d;
         rgb_q       <= rgb_d;
      end
   end

   assign red       = rgb_q.r;
   assign green     = rgb_q.g;
   assign blue      = rgb_q.b;
   assign busy      = busy_q;
   assign fade_done = fade_done_q;

endmodule

// File: tb/tb_start_fade_ctrl.sv
// Bench for start_fade_ctrl: tick-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_start_fade_ctrl;

   localparam int F = 2;
   localparam int M_BLACK = 0, M_IN = 1, M_SHOW = 2, M_OUT = 3, M_DONE = 4;

   logic       Clk;
   logic       Reset;
   logic       vsync;
   logic       start_key;
   logic       blank;
   logic [3:0] pix_index;
   logic [3:0] pal_index;
   logic [3:0] pal_red, pal_green, pal_blue;
   logic [3:0] red, green, blue;
   logic       busy;
   logic       fade_done;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;

   start_fade_ctrl #(.FRAMES_PER_STEP(F)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .vsync     (vsync),
      .start_key (start_key),
      .blank     (blank),
      .pix_index (pix_index),
      .pal_index (pal_index),
      .pal_red   (pal_red),
      .pal_green (pal_green),
      .pal_blue  (pal_blue),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .busy      (busy),
      .fade_done (fade_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: brightness derived from ticks counted since fade entry.
   function automatic int lvl_of(input int mode, input int nt);
      case (mode)
         M_IN:    return nt / F;
         M_SHOW:  return 16;
         M_OUT:   return 16 - nt / F;
         default: return 0;
      endcase
   endfunction

   function automatic int scl(input int c, input int l);
      return (c * l) / 16;
   endfunction

   int m_mode = M_BLACK, m_nt = 0;
   bit m_pend = 0, m_pv = 0, m_ps = 1;
   int e_rgb, lvl;
   bit e_busy, e_done, tk, se;

   always begin
      @(posedge Clk);
      if (Reset) begin
         m_mode = M_BLACK; m_nt = 0; m_pend = 0; m_pv = 0; m_ps = 1;
         e_rgb = 0; e_busy = 0; e_done = 0;
      end else begin
         lvl    = lvl_of(m_mode, m_nt);
         e_rgb  = blank ? ((scl(int'(pal_red), lvl) << 8) | (scl(int'(pal_green), lvl) << 4)
                           | scl(int'(pal_blue), lvl)) : 0;
         e_busy = (m_mode == M_IN) || (m_mode == M_OUT);
         e_done = 0;
         tk = m_pv && !vsync;
         se = !m_ps && start_key;
         case (m_mode)
            M_BLACK: begin
               if (se) m_pend = 1;
               if (tk) begin m_mode = M_IN; m_nt = 0; end
            end
            M_IN: begin
               if (se) m_pend = 1;
               if (tk) begin
                  m_nt++;
                  if (m_nt == 16 * F) begin
                     if (m_pend) begin m_mode = M_OUT; m_nt = 0; m_pend = 0; end
                     else m_mode = M_SHOW;
                  end
               end
            end
            M_SHOW: if (se) begin m_mode = M_OUT; m_nt = 0; m_pend = 0; end
            M_OUT: if (tk) begin
               m_nt++;
               if (m_nt == 16 * F) begin m_mode = M_DONE; e_done = 1; end
            end
            default: ;
         endcase
         m_pv = vsync;
         m_ps = start_key;
      end
      #1;
      chk("rgb", int'({red, green, blue}), e_rgb);
      chk("busy", int'(busy), int'(e_busy));
      chk("fade_done", int'(fade_done), int'(e_done));
      chk("pal_index", int'(pal_index), int'(pix_index));
   end

   always begin
      @(posedge Clk);
      #2;
      if (fade_done) done_cnt++;
   end

   task automatic frame();
      vsync = 1'b0;
      @(negedge Clk);
      vsync = 1'b1;
      repeat (3) @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic pulse_start();
      start_key = 1'b1;
      @(negedge Clk);
      start_key = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic set_pal(input logic [11:0] c);
      pal_red = c[11:8]; pal_green = c[7:4]; pal_blue = c[3:0];
   endtask

   function automatic int rgb_now();
      return int'({red, green, blue});
   endfunction

   int k;

   initial begin
      Reset = 1'b1; vsync = 1'b1; start_key = 1'b0; blank = 1'b1; pix_index = 4'h3;
      set_pal(12'hFFF);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      chk("reset_rgb", rgb_now(), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(fade_done), 0);

      // Fade-in ramp
      frame();
      chk("fi_entry_rgb", rgb_now(), 'h000);
      chk("fi_entry_busy", int'(busy), 1);
      repeat (2) frame();
      chk("fi_lvl1_rgb", rgb_now(), 'h000);
      repeat (28) frame();
      chk("fi_lvl15_rgb", rgb_now(), 'hEEE);
      repeat (2) frame();
      chk("show_rgb", rgb_now(), 'hFFF);
      chk("show_busy", int'(busy), 0);

      // Fade-out from SHOW
      pulse_start();
      chk("fo_busy", int'(busy), 1);
      repeat (16) frame();
      chk("fo_half_rgb", rgb_now(), 'h777);
      repeat (15) frame();
      done_cnt = 0;
      frame();
      chk("fo_done_once", done_cnt, 1);
      chk("fo_end_rgb", rgb_now(), 'h000);
      repeat (3) frame();
      pulse_start();
      chk("done_no_repeat", done_cnt, 1);

      // Press during fade-in skips SHOW
      do_reset();
      frame();
      repeat (10) frame();
      chk("fi_lvl5_rgb", rgb_now(), 'h444);
      pulse_start();
      done_cnt = 0;
      k = 10;
      while (done_cnt == 0 && k < 100) begin
         frame();
         k++;
      end
      chk("pending_total_ticks", k, 64);

      // Key held through reset must not start a fade-out
      start_key = 1'b1;
      do_reset();
      repeat (33) frame();
      chk("held_show_rgb", rgb_now(), 'hFFF);
      repeat (2) frame();
      chk("held_no_fo", int'(busy), 0);
      start_key = 1'b0;
      repeat (2) @(negedge Clk);
      start_key = 1'b1;
      repeat (3) @(negedge Clk);
      chk("repress_fo", int'(busy), 1);
      start_key = 1'b0;

      // blank gating in SHOW
      do_reset();
      repeat (33) frame();
      set_pal(12'hA52);
      blank = 1'b1;
      @(negedge Clk);
      chk("blank1_rgb", rgb_now(), 'hA52);
      blank = 1'b0;
      @(negedge Clk);
      chk("blank0_rgb", rgb_now(), 'h000);
      blank = 1'b1;
      @(negedge Clk);
      chk("blank1b_rgb", rgb_now(), 'hA52);

      // Reset mid fade-out
      set_pal(12'hFFF);
      pulse_start();
      repeat (12) frame();
      chk("fo_lvl10_rgb", rgb_now(), 'h999);
      done_cnt = 0;
      Reset = 1'b1;
      @(negedge Clk);
      chk("midrst_rgb", rgb_now(), 0);
      chk("midrst_busy", int'(busy), 0);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);
      chk("midrst_no_done", done_cnt, 0);
      frame();
      chk("restart_busy", int'(busy), 1);
      chk("restart_rgb", rgb_now(), 0);
      repeat (4) frame();
      chk("restart_lvl2_rgb", rgb_now(), 'h111);

      // Randomized traffic against the model
      for (int i = 0; i < 15000; i++) begin
         @(negedge Clk);
         Reset     = ($urandom_range(0, 2999) == 0);
         vsync     = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 79) == 0) start_key = ~start_key;
         blank     = ($urandom_range(0, 7) != 0);
         pix_index = 4'($urandom);
         set_pal(12'($urandom));
      end
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
